// File: rtl/multdiv_iter.sv
// Iterative signed multiplier/divider: shift-add multiply and restoring
// divide on operand magnitudes, one bit per clock, ready/valid handshake.
module multdiv_iter #(
   parameter int unsigned WA = 32,
   parameter int unsigned WB = 16
) (
   input  logic          clock,
   input  logic          ctrl_reset,
   input  logic [WA-1:0] data_operandA,
   input  logic [WB-1:0] data_operandB,
   input  logic          ctrl_MULT,
   input  logic          ctrl_DIV,
   output logic [WA-1:0] data_result,
   output logic [WB-1:0] data_remainder,
   output logic          data_exception,
   output logic          data_inputRDY,
   output logic          data_resultRDY
);

   localparam int unsigned CW = $clog2(WA) + 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WA-1:0]   mag_q, mag_d;      // |A| for multiply, |B| for divide
   logic [WA:0]     acc_q, acc_d;      // product high part / partial remainder
   logic [WA-1:0]   low_q, low_d;      // multiplier bits / dividend-quotient
   logic            neg_res_q, neg_res_d;
   logic            neg_rem_q, neg_rem_d;
   logic [WA-1:0]   result_q, result_d;
   logic [WB-1:0]   rem_q, rem_d;
   logic            exc_q, exc_d;
   logic            inrdy_q, inrdy_d;
   logic            resrdy_q, resrdy_d;

   logic [WA-1:0]    abs_a;
   logic [WB-1:0]    abs_b;
   logic [WA:0]      madd;
   logic [WA+WB:0]   mstep;
   logic [WA+WB-1:0] mprod;
   logic [WA+WB-1:0] mfull;
   logic             mul_ovf;
   logic [WB:0]      r_sh;
   logic [WB:0]      trial;
   logic [WB:0]      rnew;
   logic [WA-1:0]    qnext;
   logic [WA-1:0]    quo;
   logic [WB-1:0]    remv;

   // Next-state, datapath step and result formatting
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mag_d     = mag_q;
      acc_d     = acc_q;
      low_d     = low_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      rem_d     = rem_q;
      exc_d     = exc_q;

      abs_a = data_operandA[WA-1] ? -data_operandA : data_operandA;
      abs_b = data_operandB[WB-1] ? -data_operandB : data_operandB;

      // one shift-add multiply step
      madd    = acc_q + (low_q[0] ? {1'b0, mag_q} : '0);
      mstep   = {madd, low_q[WB-1:0]} >> 1;
      mprod   = mstep[WA+WB-1:0];
      mfull   = neg_res_q ? -mprod : mprod;
      mul_ovf = (mfull[WA+WB-1:WA-1] != {(WB+1){mfull[WA-1]}});

      // one restoring divide step
      r_sh  = {acc_q[WB-1:0], low_q[WA-1]};
      trial = r_sh - {1'b0, mag_q[WB-1:0]};
      rnew  = trial[WB] ? r_sh : trial;
      qnext = {low_q[WA-2:0], ~trial[WB]};
      quo   = neg_res_q ? -qnext : qnext;
      remv  = neg_rem_q ? -rnew[WB-1:0] : rnew[WB-1:0];

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (ctrl_MULT) begin
               state_d   = S_MUL;
               cnt_d     = '0;
               mag_d     = abs_a;
               acc_d     = '0;
               low_d     = WA'(abs_b);
               neg_res_d = data_operandA[WA-1] ^ data_operandB[WB-1];
            end else if (ctrl_DIV) begin
               if (data_operandB == '0) begin
                  // divide-by-zero resolves at the accept edge
                  state_d  = S_DONE;
                  result_d = '0;
                  rem_d    = '0;
                  exc_d    = 1'b1;
               end else begin
                  state_d   = S_DIV;
                  cnt_d     = '0;
                  mag_d     = WA'(abs_b);
                  acc_d     = '0;
                  low_d     = abs_a;
                  neg_res_d = data_operandA[WA-1] ^ data_operandB[WB-1];
                  neg_rem_d = data_operandA[WA-1];
               end
            end
         end
         S_MUL: begin
            acc_d          = mstep[WA+WB:WB];
            low_d[WB-1:0]  = mstep[WB-1:0];
            cnt_d          = cnt_q + CW'(1);
            if (cnt_q == CW'(WB-1)) begin
               state_d  = S_DONE;
               result_d = mfull[WA-1:0];
               rem_d    = '0;
               exc_d    = mul_ovf;
            end
         end
         S_DIV: begin
            acc_d = (WA+1)'(rnew);
            low_d = qnext;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WA-1)) begin
               state_d  = S_DONE;
               result_d = quo;
               rem_d    = remv;
               // positive quotient magnitude with top bit set cannot be represented
               exc_d    = ~neg_res_q & qnext[WA-1];
            end
         end
         default: state_d = S_IDLE;
      endcase

      inrdy_d  = (state_d == S_IDLE) || (state_d == S_DONE);
      resrdy_d = (state_d == S_DONE);
   end

   // State, datapath and registered outputs
   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         mag_q     <= '0;
         acc_q     <= '0;
         low_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         rem_q     <= '0;
         exc_q     <= 1'b0;
         inrdy_q   <= 1'b1;
         resrdy_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mag_q     <= mag_d;
         acc_q     <= acc_d;
         low_q     <= low_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         rem_q     <= rem_d;
         exc_q     <= exc_d;
         inrdy_q   <= inrdy_d;
         resrdy_q  <= resrdy_d;
      end
   end

   assign data_result    = result_q;
   assign data_remainder = rem_q;
   assign data_exception = exc_q;
   assign data_inputRDY  = inrdy_q;
   assign data_resultRDY = resrdy_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// Bench for multdiv_iter: arithmetic model checked every cycle plus
// directed vectors with hand-computed results and latencies.
module tb_multdiv_iter;

   localparam int unsigned WA = 32;
   localparam int unsigned WB = 16;
   localparam int LAT_MUL = WB + 1;
   localparam int LAT_DIV = WA + 1;
   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   logic          clock = 1'b0;
   logic          ctrl_reset;
   logic [WA-1:0] opa;
   logic [WB-1:0] opb;
   logic          ctrl_MULT;
   logic          ctrl_DIV;
   logic [WA-1:0] data_result;
   logic [WB-1:0] data_remainder;
   logic          data_exception;
   logic          data_inputRDY;
   logic          data_resultRDY;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   multdiv_iter #(.WA(WA), .WB(WB)) dut (
      .clock          (clock),
      .ctrl_reset     (ctrl_reset),
      .data_operandA  (opa),
      .data_operandB  (opb),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_remainder (data_remainder),
      .data_exception (data_exception),
      .data_inputRDY  (data_inputRDY),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Arithmetic reference: signed 64-bit math, truncating division
   function automatic void model(input bit is_mul, input logic [WA-1:0] a, input logic [WB-1:0] b,
                                 output logic [WA-1:0] r, output logic [WB-1:0] rm,
                                 output logic ex, output int lat);
      longint sa, sb, p, q, rr;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      if (is_mul) begin
         p   = sa * sb;
         r   = WA'(p);
         rm  = '0;
         ex  = (p > MAXV) || (p < MINV);
         lat = LAT_MUL;
      end else if (sb == 0) begin
         r = '0; rm = '0; ex = 1'b1; lat = 1;
      end else begin
         q   = sa / sb;
         rr  = sa % sb;
         r   = WA'(q);
         rm  = WB'(rr);
         ex  = (q > MAXV) || (q < MINV);
         lat = LAT_DIV;
      end
   endfunction

   // Cycle-level expectation: accept when ready, result appears after latency
   bit            m_in = 1'b1, m_rrdy = 1'b0, m_exc = 1'b0;
   logic [WA-1:0] m_res = '0, p_res;
   logic [WB-1:0] m_rem = '0, p_rem;
   logic          p_exc;
   int            m_cnt = 0, m_lat;

   always @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         m_in = 1'b1; m_rrdy = 1'b0; m_res = '0; m_rem = '0; m_exc = 1'b0; m_cnt = 0;
      end else if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_rrdy = 1'b1; m_in = 1'b1;
            m_res = p_res; m_rem = p_rem; m_exc = p_exc;
         end
      end else begin
         m_rrdy = 1'b0;
         if (ctrl_MULT || ctrl_DIV) begin
            model(ctrl_MULT, opa, opb, p_res, p_rem, p_exc, m_lat);
            if (m_lat == 1) begin
               m_rrdy = 1'b1;
               m_res = p_res; m_rem = p_rem; m_exc = p_exc;
            end else begin
               m_cnt = m_lat - 1;
               m_in  = 1'b0;
            end
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clock) begin
      if (cmp_en) begin
         chk("inputRDY",  data_inputRDY,  m_in);
         chk("resultRDY", data_resultRDY, m_rrdy);
         chk("result",    data_result,    m_res);
         chk("remainder", data_remainder, m_rem);
         chk("exception", data_exception, m_exc);
      end
   end

   // Drive a start at the current negedge; operands scrambled once accepted
   task automatic start_op(input logic m, input logic d, input logic [WA-1:0] a,
                           input logic [WB-1:0] b, input logic hold_mult);
      ctrl_MULT = m; ctrl_DIV = d; opa = a; opb = b;
      @(negedge clock);
      ctrl_MULT = hold_mult; ctrl_DIV = 1'b0;
      opa = $urandom; opb = WB'($urandom);
   endtask

   // Wait (bounded) for resultRDY, then pin latency and values to literals
   task automatic wait_result(input string name, input int exp_lat, input logic [WA-1:0] er,
                              input logic [WB-1:0] erm, input logic ee);
      int n = 1;
      while (data_resultRDY !== 1'b1 && n < 200) begin
         @(negedge clock);
         n++;
      end
      chk({name, "_rdy"}, data_resultRDY, 1'b1);
      chk({name, "_lat"}, n, exp_lat);
      chk({name, "_res"}, data_result, er);
      chk({name, "_rem"}, data_remainder, erm);
      chk({name, "_exc"}, data_exception, ee);
   endtask

   task automatic run(input string name, input logic m, input logic d, input logic [WA-1:0] a,
                      input logic [WB-1:0] b, input int lat, input logic [WA-1:0] er,
                      input logic [WB-1:0] erm, input logic ee);
      start_op(m, d, a, b, 1'b0);
      wait_result(name, lat, er, erm, ee);
      @(negedge clock);
   endtask

   initial begin
      int pulses;
      ctrl_reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; opa = '0; opb = '0;
      #3 ctrl_reset = 1'b0;
      cmp_en = 1'b1;
      repeat (2) @(negedge clock);
      chk("rst_result", data_result, 32'h0);
      chk("rst_rem", data_remainder, 16'h0);
      chk("rst_exc", data_exception, 1'b0);
      chk("rst_inrdy", data_inputRDY, 1'b1);
      chk("rst_resrdy", data_resultRDY, 1'b0);
      #2 ctrl_reset = 1'b1;
      @(negedge clock);

      run("mul1",   1, 0, 32'd1234,     16'hFDC9, 17, 32'hFFF552E2, 16'h0000, 1'b0);
      run("mulovf", 1, 0, 32'h00020000, 16'h4000, 17, 32'h80000000, 16'h0000, 1'b1);
      run("div1",   0, 1, 32'hFFFFFF9C, 16'd7,    33, 32'hFFFFFFF2, 16'hFFFE, 1'b0);
      run("dbz",    0, 1, 32'd5,        16'h0000,  1, 32'h00000000, 16'h0000, 1'b1);
      run("divovf", 0, 1, 32'h80000000, 16'hFFFF, 33, 32'h80000000, 16'h0000, 1'b1);
      run("div2",   0, 1, 32'd100,      16'hFFF9, 33, 32'hFFFFFFF2, 16'h0002, 1'b0);
      run("div3",   0, 1, 32'hFFFFFF9C, 16'hFFF9, 33, 32'h0000000E, 16'hFFFE, 1'b0);
      run("div4",   0, 1, 32'h7FFFFFFF, 16'h8000, 33, 32'hFFFF0001, 16'h7FFF, 1'b0);
      run("mul2",   1, 0, 32'h80000000, 16'hFFFF, 17, 32'h80000000, 16'h0000, 1'b1);
      run("mul3",   1, 0, 32'hFFFFFFFF, 16'hFFFF, 17, 32'h00000001, 16'h0000, 1'b0);
      run("both",   1, 1, 32'd6,        16'd7,    17, 32'd42,       16'h0000, 1'b0);

      // abort a divide with reset while ctrl_MULT is held during busy
      start_op(0, 1, 32'd1000, 16'd3, 1'b1);
      repeat (9) @(negedge clock);
      #2 ctrl_reset = 1'b0;
      @(negedge clock);
      chk("abort_result", data_result, 32'h0);
      chk("abort_rem", data_remainder, 16'h0);
      chk("abort_exc", data_exception, 1'b0);
      chk("abort_inrdy", data_inputRDY, 1'b1);
      chk("abort_resrdy", data_resultRDY, 1'b0);
      ctrl_MULT = 1'b0;
      repeat (2) @(negedge clock);
      #2 ctrl_reset = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(negedge clock);
         if (data_resultRDY === 1'b1) pulses++;
      end
      chk("abort_no_pulse", pulses, 0);

      // back-to-back: restart in the DONE cycle
      start_op(1, 0, 32'd3, 16'd4, 1'b0);
      wait_result("mul34", 17, 32'd12, 16'h0000, 1'b0);
      start_op(1, 0, 32'd5, 16'hFFFB, 1'b0);
      wait_result("b2b", 17, 32'hFFFFFFE7, 16'h0000, 1'b0);
      repeat (3) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
